lcd_hd44780_ctrl: RTL and testbench
===================================

Name: lcd_hd44780_ctrl

Overview:
Hardware HD44780 character-LCD controller. It sits between the core's LCD output path and the board LCD pins, and replaces software bit-banging of the LCD register. The core pushes one command or data byte per valid/ready handshake. The block generates RS/RW/EN/DATA timing, waits out the command execution time, and presents the pin state packed in the same 32-bit LCD word format as the I/O bus: bit31 ON, bit10 EN, bit9 RS, bit8 RW, bits7:0 DATA, all other bits 0.

Parameters:
T_SETUP, 4, cycles RS/DATA stable before EN rises
T_PULSE, 12, cycles EN held high
T_HOLD, 4, cycles RS/DATA held after EN falls
T_EXEC, 2000, execution wait for normal commands/data (40 us at 50 MHz)
T_EXEC_LONG, 82000, execution wait for clear/home (1.64 ms)
T_POWERUP, 750000, power-on wait before init (15 ms)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous reset, active-low
i_valid  in  1  request present
i_rs  in  1  0 = command, 1 = data byte
i_data  in  8  byte to write
o_ready  out  1  accepting a request this cycle
o_init_done  out  1  init sequence complete (sticky until reset)
o_io_lcd  out  32  packed pin word {ON,20'b0,EN,RS,RW,DATA[7:0]}

Behaviour:
- Reset (i_reset = 0, async): state POWERUP (or IDLE without macro); o_ready=0, o_init_done=0, o_io_lcd=0, all counters 0.
- ON (bit31) = 1 in every cycle after reset release. RW (bit8) is always 0; the block is write-only.
- States: POWERUP, INIT_ISSUE, IDLE, SETUP, PULSE, HOLD, EXEC. A single down/up counter is sized by $clog2 of the largest parameter + 1.
- POWERUP: counts T_POWERUP cycles -> INIT_ISSUE.
- INIT_ISSUE: loads init byte idx (2-bit index: 0x38, 0x0C, 0x01, 0x06; RS=0) -> SETUP.
- IDLE: o_ready=1 only here (and only once o_init_done=1). On i_valid & o_ready, latch i_rs/i_data -> SETUP. i_valid while o_ready=0 is ignored; the requester holds it.
- SETUP: T_SETUP cycles with RS/DATA driven, EN=0. PULSE: T_PULSE cycles with EN=1. HOLD: T_HOLD cycles with EN=0, RS/DATA unchanged. EXEC: wait T_EXEC_LONG if RS=0 and DATA in {0x01,0x02,0x03}, else T_EXEC.
- After EXEC: if in init and idx<3, idx++ -> INIT_ISSUE. If in init and idx=3, set o_init_done -> IDLE. Otherwise -> IDLE.
- Latency: after acceptance edge k, EN rises at edge k+T_SETUP and falls at k+T_SETUP+T_PULSE. o_ready reasserts at k+T_SETUP+T_PULSE+T_HOLD+Texec.
- RS/DATA keep their last driven value in IDLE; EN is never 1 outside PULSE.
- Back-to-back: a request held high across IDLE is accepted on the first IDLE cycle; there is no bubble beyond IDLE's single cycle.
- Reset mid-transfer: EN drops to 0 immediately (async), the transfer is discarded, and the init sequence restarts.
- Any parameter value of 0 is treated as 1 cycle.

Optional Feature:
LCD_INIT_EN defined: power-on wait plus the 4-command init sequence (0x38, 0x0C, 0x01, 0x06) as above. o_ready first asserts after T_POWERUP + the 4 command timings.
LCD_INIT_EN undefined: POWERUP/INIT_ISSUE are absent. Reset goes to IDLE, o_init_done=1 and o_ready=1 from the first cycle after reset release, and software performs init itself.

Test Plan:
(All with T_SETUP=2, T_PULSE=3, T_HOLD=2, T_EXEC=5, T_EXEC_LONG=20, T_POWERUP=10.)
- Init on, reset release -> EN pulses 4 times with DATA 0x38, 0x0C, 0x01, 0x06 and RS=0. The gap after 0x01 uses 20 exec cycles. o_init_done and o_ready rise at cycle 10+4*7+3*5+20=73.
- In IDLE, i_valid=1, i_rs=1, i_data=0x41 -> o_io_lcd=0x8000_0241 for SETUP, then 0x8000_0641 for exactly 3 cycles, then 0x8000_0241 for 2 cycles. o_ready returns 12 cycles after acceptance.
- Command 0x01 (RS=0) -> o_ready returns 27 cycles after acceptance. Command 0x80 -> returns after 12 cycles.
- i_valid held high with 3 different bytes changed on each accept -> 3 EN pulses spaced exactly 13 cycles apart, each carrying the correct byte. Pulses toggled while busy are ignored.
- Assert i_reset=0 during PULSE -> o_io_lcd=0 in the same cycle. On release, the init sequence restarts from POWERUP.
- LCD_INIT_EN undefined: o_ready=1 and o_init_done=1 in the first cycle after reset release, and no EN pulse appears without a request.

Source files
------------

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD write controller; macro LCD_INIT_EN adds power-on wait + 4-command init.
// Latency: EN rises T_SETUP cycles after accept, ready returns after T_SETUP+T_PULSE+T_HOLD+exec wait.
// Backpressure: o_ready is high only in IDLE; the requester holds i_valid until accepted.
module lcd_hd44780_ctrl #(
    parameter int T_SETUP     = 4,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 4,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000,
    parameter int T_POWERUP   = 750000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_rs,
    input  logic [7:0]  i_data,
    output logic        o_ready,
    output logic        o_init_done,
    output logic [31:0] o_io_lcd
);

    function automatic int at_least_1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int P_SETUP     = at_least_1(T_SETUP);
    localparam int P_PULSE     = at_least_1(T_PULSE);
    localparam int P_HOLD      = at_least_1(T_HOLD);
    localparam int P_EXEC      = at_least_1(T_EXEC);
    localparam int P_EXEC_LONG = at_least_1(T_EXEC_LONG);
    localparam int P_POWERUP   = at_least_1(T_POWERUP);
    localparam int P_MAX = max2(max2(max2(P_SETUP, P_PULSE), max2(P_HOLD, P_EXEC)),
                                max2(P_EXEC_LONG, P_POWERUP));
    localparam int CW = $clog2(P_MAX + 1);

    typedef logic [CW-1:0] cnt_t;

    typedef enum logic [2:0] {
`ifdef LCD_INIT_EN
        POWERUP,
        INIT_ISSUE,
`endif
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } state_t;

`ifdef LCD_INIT_EN
    localparam state_t RST_STATE = POWERUP;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t     state, state_nxt;
    cnt_t       cnt;
    cnt_t       lim;
    cnt_t       exec_len;
    logic       rs_q;
    logic [7:0] data_q;
    logic       on_q;
    logic       init_done;
    logic       ld_req;
    logic       long_cmd;

    assign long_cmd = !rs_q && (data_q inside {8'h01, 8'h02, 8'h03});
    assign exec_len = long_cmd ? cnt_t'(P_EXEC_LONG) : cnt_t'(P_EXEC);

`ifdef LCD_INIT_EN
    logic [1:0] idx;
    logic       ld_init;
    logic       idx_inc;
    logic       set_done;
    logic [7:0] init_byte;
    cnt_t       exec_len_init;

    // The INIT_ISSUE cycle is taken out of the preceding wait, so init pacing
    // is exactly T_POWERUP / Texec between commands.
    assign exec_len_init = long_cmd ? cnt_t'(max2(P_EXEC_LONG - 1, 1))
                                    : cnt_t'(max2(P_EXEC - 1, 1));

    always_comb begin
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    end
`endif

    always_comb begin
        state_nxt = state;
        lim       = cnt_t'(1);
        ld_req    = 1'b0;
`ifdef LCD_INIT_EN
        ld_init   = 1'b0;
        idx_inc   = 1'b0;
        set_done  = 1'b0;
`endif
        case (state)
`ifdef LCD_INIT_EN
            POWERUP: begin
                lim = cnt_t'(max2(P_POWERUP - 1, 1));
                if (cnt == lim - cnt_t'(1)) state_nxt = INIT_ISSUE;
            end
            INIT_ISSUE: begin
                ld_init   = 1'b1;
                state_nxt = SETUP;
            end
`endif
            IDLE: begin
                if (i_valid && o_ready) begin
                    ld_req    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                lim = cnt_t'(P_SETUP);
                if (cnt == lim - cnt_t'(1)) state_nxt = PULSE;
            end
            PULSE: begin
                lim = cnt_t'(P_PULSE);
                if (cnt == lim - cnt_t'(1)) state_nxt = HOLD;
            end
            HOLD: begin
                lim = cnt_t'(P_HOLD);
                if (cnt == lim - cnt_t'(1)) state_nxt = EXEC;
            end
            EXEC: begin
                lim = exec_len;
`ifdef LCD_INIT_EN
                if (!init_done && idx != 2'd3) lim = exec_len_init;
                if (cnt == lim - cnt_t'(1)) begin
                    if (!init_done && idx != 2'd3) begin
                        idx_inc   = 1'b1;
                        state_nxt = INIT_ISSUE;
                    end else begin
                        set_done  = !init_done;
                        state_nxt = IDLE;
                    end
                end
`else
                if (cnt == lim - cnt_t'(1)) state_nxt = IDLE;
`endif
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state || state == IDLE) ? '0 : cnt + cnt_t'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rs_q      <= 1'b0;
            data_q    <= 8'h00;
            on_q      <= 1'b0;
            init_done <= 1'b0;
`ifdef LCD_INIT_EN
            idx       <= 2'd0;
`endif
        end else begin
            on_q <= 1'b1;
            if (ld_req) begin
                rs_q   <= i_rs;
                data_q <= i_data;
            end
`ifdef LCD_INIT_EN
            if (ld_init) begin
                rs_q   <= 1'b0;
                data_q <= init_byte;
            end
            if (idx_inc)  idx       <= idx + 2'd1;
            if (set_done) init_done <= 1'b1;
`else
            init_done <= 1'b1;
`endif
        end
    end

    assign o_ready     = (state == IDLE) && init_done;
    assign o_init_done = init_done;
    assign o_io_lcd    = {on_q, 20'b0, (state == PULSE), rs_q, 1'b0, data_q};

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench for lcd_hd44780_ctrl: expected pin bytes are queued on accept and checked at each EN pulse.
module tb_lcd_hd44780_ctrl;

    localparam int TS = 2, TP = 3, TH = 2, TE = 5, TEL = 20, TPW = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_rs = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic        o_ready;
    logic        o_init_done;
    logic [31:0] o_io_lcd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [8:0]  exp_q[$];
    int          rise_q[$];
    logic [31:0] prev_w = '0;
    logic [31:0] cur = '0;
    logic        en_prev = 1'b0;
    int          hi = 0;

    lcd_hd44780_ctrl #(
        .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH),
        .T_EXEC(TE), .T_EXEC_LONG(TEL), .T_POWERUP(TPW)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_valid(i_valid), .i_rs(i_rs),
        .i_data(i_data), .o_ready(o_ready), .o_init_done(o_init_done),
        .o_io_lcd(o_io_lcd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input logic rs, input logic [7:0] d);
        return TS + TP + TH + ((!rs && d >= 8'h01 && d <= 8'h03) ? TEL : TE);
    endfunction

    function automatic logic [31:0] word(input logic [8:0] e);
        return {1'b1, 21'b0, e[8], 1'b0, e[7:0]};
    endfunction

    // Pin monitor: pops the scoreboard at every EN rise and checks the surrounding words.
    always @(posedge clk) begin
        logic [31:0] w;
        logic [8:0]  e;
        #1;
        w = o_io_lcd;
        if (!rst_n) begin
            en_prev = 1'b0;
            hi = 0;
        end else begin
            if (w[10] && !en_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", w, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    cur = word(e);
                    chk("pulse_word", w, cur | 32'h400);
                    chk("setup_word", prev_w, cur);
                end
                rise_q.push_back(cyc);
            end
            if (w[10]) hi++;
            if (!w[10] && en_prev) begin
                chk("pulse_width", hi, TP);
                chk("hold_word", w, cur);
                hi = 0;
            end
            en_prev = w[10];
        end
        prev_w = w;
    end

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (!o_ready && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!o_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic rs, input logic [7:0] d);
        int n;
        wait_ready(200, n);
        i_valid = 1'b1;
        i_rs    = rs;
        i_data  = d;
        @(posedge clk);
        #1;
        exp_q.push_back({rs, d});
        i_valid = 1'b0;
        i_data  = 8'hEE;
        chk("busy_after_accept", o_ready, 1'b0);
        wait_ready(200, n);
        chk("ready_latency", n, exp_lat(rs, d));
    endtask

    task automatic release_and_init(input string tag);
        int n;
        logic [7:0] ib[4];
        ib = '{8'h38, 8'h0C, 8'h01, 8'h06};
`ifdef LCD_INIT_EN
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, ib[i]});
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready(300, n);
`ifdef LCD_INIT_EN
        chk({tag, "_init_cycles"}, n, TPW + 4 * (TS + TP + TH) + 3 * TE + TEL);
`else
        chk({tag, "_ready_first_cycle"}, n, 1);
`endif
        chk({tag, "_init_done"}, o_init_done, 1'b1);
        chk({tag, "_on_bit"}, o_io_lcd[31], 1'b1);
        chk({tag, "_init_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        logic [7:0] bb[3];
        bb = '{8'h48, 8'h49, 8'h21};

        #12;
        chk("rst_io_lcd", o_io_lcd, 32'h0);
        chk("rst_ready", o_ready, 1'b0);
        chk("rst_init_done", o_init_done, 1'b0);

        release_and_init("first");

        rise_q.delete();
        repeat (30) @(posedge clk);
        #1;
        chk("idle_no_pulse", rise_q.size(), 0);
        chk("idle_ready", o_ready, 1'b1);

        send(1'b1, 8'h41);
        chk("idle_keeps_word", o_io_lcd, 32'h8000_0241);
        send(1'b0, 8'h01);
        send(1'b0, 8'h80);
        send(1'b0, 8'h02);
        send(1'b0, 8'h03);
        send(1'b1, 8'h03);
        send(1'b0, 8'h04);

        // Back-to-back: valid held high, junk data while busy.
        rise_q.delete();
        i_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            n = 0;
            while (!o_ready && n < 100) begin
                i_data = 8'($urandom);
                i_rs   = 1'($urandom);
                @(posedge clk);
                #1;
                n++;
            end
            if (!o_ready) chk("b2b_timeout", 32'd0, 32'd1);
            i_rs   = 1'b1;
            i_data = bb[j];
            @(posedge clk);
            #1;
            exp_q.push_back({1'b1, bb[j]});
        end
        i_valid = 1'b0;
        wait_ready(100, n);
        chk("b2b_pulses", rise_q.size(), 3);
        if (rise_q.size() == 3) begin
            chk("b2b_gap0", rise_q[1] - rise_q[0], TS + TP + TH + TE + 1);
            chk("b2b_gap1", rise_q[2] - rise_q[1], TS + TP + TH + TE + 1);
        end

        // Reset in the middle of an EN pulse.
        wait_ready(100, n);
        i_valid = 1'b1;
        i_rs    = 1'b1;
        i_data  = 8'h5A;
        @(posedge clk);
        #1;
        exp_q.push_back({1'b1, 8'h5A});
        i_valid = 1'b0;
        n = 0;
        while (!o_io_lcd[10] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pulse_seen_before_reset", o_io_lcd[10], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_pulse_reset_word", o_io_lcd, 32'h0);
        chk("mid_pulse_reset_ready", o_ready, 1'b0);
        chk("mid_pulse_reset_done", o_init_done, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("held_reset_word", o_io_lcd, 32'h0);

        release_and_init("restart");
        send(1'b1, 8'h7E);
        send(1'b0, 8'h01);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
